// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register-file slave.
// Optional byte strobes are enabled with the APB_SLV_PSTRB_EN macro.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int WAIT_STATES_MAX = 15;
    localparam int WAIT_CNT_W      = 4;

    // Byte-offset bits inside one data word (8->0, 16->1, 32->2, 64->3).
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_slv_if.sv
// APB bus bundle between a master and the register-file slave.
// pstrb exists only when APB_SLV_PSTRB_EN is defined.
interface apb_slv_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    // Handshake: a transfer is a setup cycle (pselx=1, penable=0) followed by
    // access cycles (pselx=1, penable=1) with all request fields held stable;
    // it completes on the rising edge where pready=1, and pslave_error/prdata
    // are meaningful only in that cycle.
    logic                    pselx;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_SLV_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] pstrb;
`endif
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslave_error;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
`ifdef APB_SLV_PSTRB_EN
        output pstrb,
`endif
        input  prdata, pready, pslave_error
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
`ifdef APB_SLV_PSTRB_EN
        input  pstrb,
`endif
        output prdata, pready, pslave_error
    );

endinterface

// File: rtl/apb_slv_regfile.sv
// DEPTH x DATA_WIDTH register array: synchronous clear, byte-strobed
// write port and combinational read port.
module apb_slv_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [IDX_WIDTH-1:0]    i_widx,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    input  logic [IDX_WIDTH-1:0]    i_ridx,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_widx == IDX_WIDTH'(i)) begin
                    for (int b = 0; b < LANES; b++) begin
                        if (i_strb[b]) r_mem[i][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Indices at or beyond DEPTH read as zero; the top never lets them through.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_ridx == IDX_WIDTH'(i)) o_rdata = r_mem[i];
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave fronting a register file: FSM, wait-state counter, error decode.
// Define APB_SLV_PSTRB_EN for byte-lane masked writes via pstrb.
module apb_regfile_slave
    import apb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic       pclk,
    input  logic       preset,
    apb_slv_if.slave   bus,
    output apb_state_t o_state
);

    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int SW       = DATA_WIDTH / 8;
    localparam int IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WS_EFF   = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << ADDR_LSB) - 1);

    apb_state_t              r_state, w_next_state;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [SW-1:0]           w_strb;
    logic                    w_capture, w_done, w_err, w_we;
    logic [ADDR_WIDTH-1:0]   w_idx_full;
    logic [IW-1:0]           w_idx;
    logic [DATA_WIDTH-1:0]   w_rdata;
`ifdef APB_SLV_PSTRB_EN
    logic [SW-1:0]           r_strb;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
`ifdef APB_SLV_PSTRB_EN
            r_strb     <= '0;
`endif
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_capture) begin
                r_addr  <= bus.paddr;
                r_write <= bus.pwrite;
                r_wdata <= bus.pwdata;
`ifdef APB_SLV_PSTRB_EN
                r_strb  <= bus.pstrb;
`endif
            end
        end
    end

`ifdef APB_SLV_PSTRB_EN
    assign w_strb = r_strb;
`else
    assign w_strb = '1;
`endif

    // SETUP is the first access cycle after capture; ACCESS covers the rest.
    always_comb begin
        w_next_state   = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_capture      = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.pselx && !bus.penable) begin
                    w_next_state   = SETUP;
                    w_capture      = 1'b1;
                    w_wait_cnt_nxt = WAIT_CNT_W'(WS_EFF);
                end
            end
            SETUP, ACCESS: begin
                if (r_wait_cnt == '0) begin
                    w_done = 1'b1;
                    if (bus.pselx && !bus.penable) begin
                        w_next_state   = SETUP;
                        w_capture      = 1'b1;
                        w_wait_cnt_nxt = WAIT_CNT_W'(WS_EFF);
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (!bus.pselx) begin
                    w_next_state   = IDLE;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_next_state   = ACCESS;
                    w_wait_cnt_nxt = r_wait_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state   = IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Error decode works only on captured request fields.
    assign w_idx_full = r_addr >> ADDR_LSB;
    assign w_idx      = IW'(w_idx_full);
    assign w_err      = (|(r_addr & LSB_MASK)) || (32'(w_idx_full) >= 32'(DEPTH));
    assign w_we       = w_done && r_write && !w_err;

    apb_slv_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IW)
    ) u_regfile (
        .i_clk   (pclk),
        .i_rst   (preset),
        .i_we    (w_we),
        .i_widx  (w_idx),
        .i_wdata (r_wdata),
        .i_strb  (w_strb),
        .i_ridx  (w_idx),
        .o_rdata (w_rdata)
    );

    assign bus.pready       = w_done;
    assign bus.pslave_error = w_done && w_err;
    assign bus.prdata       = (w_done && !r_write && !w_err) ? w_rdata : '0;
    assign o_state          = r_state;

endmodule
